// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: per-channel coalescing hold registers with a round-robin
// issue to the single DAC link. Define DAC_SCHED_STATS_EN for the coalesce counter.
module dac_update_scheduler #(
    parameter int N_CHAN = 8,
    parameter int W_CHAN = 4,
    parameter int W_DATA = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              dv_in,
    input  logic [W_CHAN-1:0] chan_in,
    input  logic [W_DATA-1:0] data_in,
    input  logic [N_CHAN-1:0] chan_en_in,
    input  logic              wr_done_in,
    output logic              dv_out,
    output logic [W_CHAN-1:0] chan_out,
    output logic [W_DATA-1:0] data_out,
    output logic              busy_out,
`ifdef DAC_SCHED_STATS_EN
    input  logic              stats_clr_in,
    output logic [15:0]       coalesce_cnt_out,
`endif
    output logic [N_CHAN-1:0] pending_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              r_state;
    logic                r_dv;
    logic                r_busy;
    logic [W_CHAN-1:0]   r_chan;
    logic [W_CHAN-1:0]   r_last;
    logic [W_DATA-1:0]   r_data;
    logic [N_CHAN-1:0]   r_pending;
    logic [W_DATA-1:0]   r_hold [N_CHAN];

    logic [N_CHAN-1:0]   w_cap;
    logic [N_CHAN-1:0]   w_clr;
    logic [N_CHAN-1:0]   w_elig;
    logic                w_any;
    logic                w_grant;
    logic [W_CHAN-1:0]   w_win;
    logic [W_DATA-1:0]   w_win_data;

    // Decode the incoming strobe; out-of-range channels match nothing.
    always_comb begin
        w_cap = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            w_cap[c] = dv_in && (chan_in == W_CHAN'(c));
        end
    end

    assign w_elig = r_pending & chan_en_in;

    // Round-robin pick: first eligible above the last grant, else lowest eligible.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (!w_any && w_elig[c] && (W_CHAN'(c) > r_last)) begin
                w_any = 1'b1;
                w_win = W_CHAN'(c);
            end
        end
        for (int c = 0; c < N_CHAN; c++) begin
            if (!w_any && w_elig[c]) begin
                w_any = 1'b1;
                w_win = W_CHAN'(c);
            end
        end
    end

    // Select the winner's held code and its pending-clear strobe.
    always_comb begin
        w_win_data = '0;
        w_clr      = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (w_win == W_CHAN'(c)) begin
                w_win_data = r_hold[c];
                w_clr[c]   = w_grant;
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && w_any;

    // Hold registers and pending flags; a capture on the grant edge wins over the clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= '0;
            for (int c = 0; c < N_CHAN; c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_cap;
            for (int c = 0; c < N_CHAN; c++) begin
                if (w_cap[c]) begin
                    r_hold[c] <= data_in;
                end
            end
        end
    end

    // Issue FSM with registered strobe, busy flag and issued channel/code.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_dv    <= 1'b0;
            r_busy  <= 1'b0;
            r_chan  <= '0;
            r_data  <= '0;
            r_last  <= W_CHAN'(N_CHAN - 1);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_chan  <= w_win;
                        r_data  <= w_win_data;
                        r_last  <= w_win;
                        r_dv    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_dv <= 1'b0;
                    if (wr_done_in) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_done_in) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_dv    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DAC_SCHED_STATS_EN
    logic [15:0] r_coal_cnt;
    logic        w_coal;

    assign w_coal = |(w_cap & r_pending);

    // Saturating count of overwrites of still-pending samples; clear has priority.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_coal_cnt <= '0;
        end else if (stats_clr_in) begin
            r_coal_cnt <= '0;
        end else if (w_coal && (r_coal_cnt != 16'hFFFF)) begin
            r_coal_cnt <= r_coal_cnt + 16'd1;
        end
    end

    assign coalesce_cnt_out = r_coal_cnt;
`endif

    assign dv_out      = r_dv;
    assign busy_out    = r_busy;
    assign chan_out    = r_chan;
    assign data_out    = r_data;
    assign pending_out = r_pending;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb_dac_update_scheduler: directed scenarios for the DAC update scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dac_update_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv_in;
    logic [3:0]  chan_in;
    logic [15:0] data_in;
    logic [7:0]  chan_en_in;
    logic        wr_done_in;
    logic        dv_out;
    logic [3:0]  chan_out;
    logic [15:0] data_out;
    logic        busy_out;
    logic [7:0]  pending_out;
`ifdef DAC_SCHED_STATS_EN
    logic        stats_clr_in = 1'b0;
    logic [15:0] coalesce_cnt_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dac_update_scheduler dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .dv_in       (dv_in),
        .chan_in     (chan_in),
        .data_in     (data_in),
        .chan_en_in  (chan_en_in),
        .wr_done_in  (wr_done_in),
        .dv_out      (dv_out),
        .chan_out    (chan_out),
        .data_out    (data_out),
        .busy_out    (busy_out),
`ifdef DAC_SCHED_STATS_EN
        .stats_clr_in     (stats_clr_in),
        .coalesce_cnt_out (coalesce_cnt_out),
`endif
        .pending_out (pending_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input logic [3:0] ch, input logic [15:0] d);
        dv_in   = 1'b1;
        chan_in = ch;
        data_in = d;
        tick();
        dv_in   = 1'b0;
    endtask

    // Bounded wait for an issue strobe; stays on the strobe cycle when found.
    task automatic wait_issue(output logic [3:0] ch, output logic [15:0] d, output bit ok);
        ok = 1'b0;
        ch = '0;
        d  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (dv_out === 1'b1) begin
                ok = 1'b1;
                ch = chan_out;
                d  = data_out;
            end else begin
                tick();
            end
        end
    endtask

    // Acknowledge the outstanding write four edges after its strobe.
    task automatic finish_write();
        repeat (3) tick();
        wr_done_in = 1'b1;
        tick();
        wr_done_in = 1'b0;
    endtask

    task automatic count_dv(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dv_out === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        dv_in      = 1'b0;
        chan_in    = '0;
        data_in    = '0;
        chan_en_in = 8'hFF;
        wr_done_in = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dv_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_dv got=%0h exp=0", dv_out);
        end
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy_out);
        end
        n_checks++;
        if (chan_out !== 4'h0 || data_out !== 16'h0) begin
            n_fail++; $display("FAIL reset_chan_data got=%0h/%0h exp=0/0", chan_out, data_out);
        end
        n_checks++;
        if (pending_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_pending got=%0h exp=0", pending_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write(4'd3, 16'h1234);
        n_checks++;
        if (pending_out !== 8'h08 || dv_out !== 1'b0) begin
            n_fail++; $display("FAIL single_capture got=%0h/%0h exp=08/0", pending_out, dv_out);
        end
        tick();
        n_checks++;
        if (dv_out !== 1'b1 || chan_out !== 4'd3 || data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_issue got=%0h/%0h/%0h exp=1/3/1234", dv_out, chan_out, data_out);
        end
        n_checks++;
        if (pending_out !== 8'h00 || busy_out !== 1'b1) begin
            n_fail++; $display("FAIL single_grant got=%0h/%0h exp=00/1", pending_out, busy_out);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (busy_out !== 1'b1 || dv_out !== 1'b0) begin
            n_fail++; $display("FAIL single_wait got=%0h/%0h exp=1/0", busy_out, dv_out);
        end
        wr_done_in = 1'b1;
        tick();
        wr_done_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || chan_out !== 4'd3 || data_out !== 16'h1234) begin
            n_fail++;
            $display("FAIL single_done got=%0h/%0h/%0h exp=0/3/1234", busy_out, chan_out, data_out);
        end
    endtask

    task automatic test_coalesce();
        logic [3:0]  ch;
        logic [15:0] d;
        bit          ok;
        int          cnt;
        write(4'd1, 16'h1111);
        tick();
        tick();
        write(4'd5, 16'h0001);
        write(4'd5, 16'h0002);
        write(4'd5, 16'h0003);
        n_checks++;
        if (pending_out !== 8'h20 || busy_out !== 1'b1) begin
            n_fail++; $display("FAIL coal_pending got=%0h/%0h exp=20/1", pending_out, busy_out);
        end
`ifdef DAC_SCHED_STATS_EN
        n_checks++;
        if (coalesce_cnt_out !== 16'd2) begin
            n_fail++; $display("FAIL coal_count got=%0d exp=2", coalesce_cnt_out);
        end
`endif
        wr_done_in = 1'b1;
        tick();
        wr_done_in = 1'b0;
        n_checks++;
        if (dv_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL coal_idle_gap got=%0h/%0h exp=0/0", dv_out, busy_out);
        end
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd5 || d !== 16'h0003) begin
            n_fail++; $display("FAIL coal_issue got=%0h/%0h/%0h exp=1/5/0003", ok, ch, d);
        end
        finish_write();
        count_dv(6, cnt);
        n_checks++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL coal_single_issue got=%0d extra issues exp=0", cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  ch;
        logic [15:0] d;
        bit          ok;
        logic [3:0]  exp_ch [3];
        logic [15:0] exp_d  [3];
        exp_ch = '{4'd0, 4'd2, 4'd7};
        exp_d  = '{16'h0A00, 16'h0A02, 16'h0A07};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chan_en_in = 8'h00;
        write(4'd0, 16'h0A00);
        write(4'd2, 16'h0A02);
        write(4'd7, 16'h0A07);
        n_checks++;
        if (pending_out !== 8'h85 || dv_out !== 1'b0) begin
            n_fail++; $display("FAIL rr_pending got=%0h/%0h exp=85/0", pending_out, dv_out);
        end
        chan_en_in = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            wait_issue(ch, d, ok);
            n_checks++;
            if (!ok || ch !== exp_ch[k] || d !== exp_d[k]) begin
                n_fail++;
                $display("FAIL rr_issue%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, ok, ch, d, exp_ch[k], exp_d[k]);
            end
            finish_write();
        end
        write(4'd2, 16'h0B02);
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd2 || d !== 16'h0B02) begin
            n_fail++; $display("FAIL rr_grant2 got=%0h/%0h/%0h exp=1/2/0b02", ok, ch, d);
        end
        write(4'd0, 16'h0B00);
        write(4'd7, 16'h0B07);
        wr_done_in = 1'b1;
        tick();
        wr_done_in = 1'b0;
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd7 || d !== 16'h0B07) begin
            n_fail++; $display("FAIL rr_wrap7 got=%0h/%0h/%0h exp=1/7/0b07", ok, ch, d);
        end
        finish_write();
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd0 || d !== 16'h0B00) begin
            n_fail++; $display("FAIL rr_wrap0 got=%0h/%0h/%0h exp=1/0/0b00", ok, ch, d);
        end
        finish_write();
    endtask

    task automatic test_mask();
        logic [3:0]  ch;
        logic [15:0] d;
        bit          ok;
        int          cnt;
        chan_en_in = 8'hFB;
        write(4'd2, 16'h2222);
        write(4'd2, 16'h2223);
        count_dv(6, cnt);
        n_checks++;
        if (cnt !== 0 || pending_out !== 8'h04) begin
            n_fail++; $display("FAIL mask_blocked got=%0d/%0h exp=0/04", cnt, pending_out);
        end
        chan_en_in = 8'hFF;
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd2 || d !== 16'h2223) begin
            n_fail++; $display("FAIL mask_release got=%0h/%0h/%0h exp=1/2/2223", ok, ch, d);
        end
        finish_write();
    endtask

    task automatic test_collision();
        logic [3:0]  ch;
        logic [15:0] d;
        bit          ok;
        chan_en_in = 8'hEF;
        dv_in   = 1'b1;
        chan_in = 4'd4;
        data_in = 16'hAAAA;
        tick();
        chan_en_in = 8'hFF;
        data_in    = 16'hBEEF;
        tick();
        dv_in = 1'b0;
        n_checks++;
        if (dv_out !== 1'b1 || chan_out !== 4'd4 || data_out !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL coll_first got=%0h/%0h/%0h exp=1/4/aaaa", dv_out, chan_out, data_out);
        end
        n_checks++;
        if (pending_out !== 8'h10) begin
            n_fail++; $display("FAIL coll_pending got=%0h exp=10", pending_out);
        end
        finish_write();
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd4 || d !== 16'hBEEF) begin
            n_fail++; $display("FAIL coll_second got=%0h/%0h/%0h exp=1/4/beef", ok, ch, d);
        end
        finish_write();
    endtask

    task automatic test_reset_wait();
        logic [3:0]  ch;
        logic [15:0] d;
        bit          ok;
        int          cnt;
        write(4'd1, 16'h0101);
        wait_issue(ch, d, ok);
        write(4'd1, 16'h0102);
        n_checks++;
        if (!ok || busy_out !== 1'b1 || pending_out !== 8'h02) begin
            n_fail++; $display("FAIL rstw_setup got=%0h/%0h/%0h exp=1/1/02", ok, busy_out, pending_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dv_out !== 1'b0 || busy_out !== 1'b0 || chan_out !== 4'h0 ||
            data_out !== 16'h0 || pending_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rstw_async got=%0h/%0h/%0h/%0h/%0h exp=0/0/0/0/0",
                     dv_out, busy_out, chan_out, data_out, pending_out);
        end
        tick();
        rst_n = 1'b1;
        count_dv(6, cnt);
        n_checks++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL rstw_quiet got=%0d exp=0", cnt);
        end
        write(4'd9, 16'hFFFF);
        count_dv(5, cnt);
        n_checks++;
        if (cnt !== 0 || pending_out !== 8'h00) begin
            n_fail++; $display("FAIL rstw_oor got=%0d/%0h exp=0/00", cnt, pending_out);
        end
        write(4'd1, 16'h0111);
        wait_issue(ch, d, ok);
        n_checks++;
        if (!ok || ch !== 4'd1 || d !== 16'h0111) begin
            n_fail++; $display("FAIL rstw_new got=%0h/%0h/%0h exp=1/1/0111", ok, ch, d);
        end
        finish_write();
    endtask

    initial begin
        test_reset();
        test_single();
        test_coalesce();
        test_round_robin();
        test_mask();
        test_collision();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
